// File: rtl/video_in_pkg.sv
// Shared types and helpers for the burst video-input store.
package video_in_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_BURST,
    S_FRAME_DONE,
    S_ERROR
  } vis_state_t;

  localparam logic [3:0] WB_SEL_ALL = 4'hF;

  function automatic int words_per_frame(input int p_width, input int p_height, input int pix_bits);
    return (p_width * p_height) / (32 / pix_bits);
  endfunction

endpackage

// File: rtl/video_in_addr_buf.sv
// Pending frame base address: a new write always wins over a same-cycle consume,
// so the consumer takes the old address and the new one stays pending.
module video_in_addr_buf (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        wr_i,
  input  logic [31:0] wr_addr_i,
  input  logic        consume_i,
  output logic        pend_valid_o,
  output logic [31:0] pend_addr_o
);

  logic        pend_valid_q;
  logic [31:0] pend_addr_q;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
    end else if (wr_i) begin
      pend_valid_q <= 1'b1;
      pend_addr_q  <= wr_addr_i;
    end else if (consume_i) begin
      pend_valid_q <= 1'b0;
    end
  end

  assign pend_valid_o = pend_valid_q;
  assign pend_addr_o  = pend_addr_q;

endmodule

// File: rtl/video_in_store_burst.sv
// Drains packed pixel words from a show-ahead FIFO into RAM as Wishbone burst writes,
// one frame per pending base address; irq pulses at frame end or on bus error.
module video_in_store_burst
  import video_in_pkg::*;
#(
  parameter int P_WIDTH   = 640,
  parameter int P_HEIGHT  = 480,
  parameter int PIX_BITS  = 8,
  parameter int BURST_LEN = 16,
  parameter int FIFO_AW   = 6
) (
  input  logic               clk,
  input  logic               RST,
  input  logic [31:0]        cfg_addr,
  input  logic               cfg_valid,
  input  logic [FIFO_AW:0]   fifo_level,
  input  logic [31:0]        fifo_data,
  output logic               fifo_rd_en,
  output logic               irq,
  output logic               err,
  output logic               busy,
  output logic               p_wb_CYC_O,
  output logic               p_wb_STB_O,
  output logic               p_wb_WE_O,
  output logic [3:0]         p_wb_SEL_O,
  output logic [31:0]        p_wb_ADR_O,
  output logic [31:0]        p_wb_DAT_O,
  input  logic               p_wb_ACK_I,
  input  logic               p_wb_ERR_I
);

  localparam int          FRAME_WORDS = words_per_frame(P_WIDTH, P_HEIGHT, PIX_BITS);
  localparam int          WCW         = $clog2(FRAME_WORDS + 1);
  localparam int unsigned BL_U        = BURST_LEN;

  vis_state_t     state_q;
  logic [31:0]    adr_q;
  logic [WCW-1:0] words_left_q;
  logic [WCW-1:0] beat_cnt_q;
  logic           cyc_q;
  logic           irq_q;
  logic           err_q;

  logic           pend_valid;
  logic [31:0]    pend_addr;
  logic           take_pend;
  logic [WCW-1:0] blen;
  logic [WCW-1:0] words_left_d;
  logic           data_ready;

  assign take_pend = ((state_q == S_IDLE) || (state_q == S_ERROR)) && pend_valid;

  video_in_addr_buf u_addr_buf (
    .clk          (clk),
    .rst_i        (RST),
    .wr_i         (cfg_valid),
    .wr_addr_i    (cfg_addr),
    .consume_i    (take_pend),
    .pend_valid_o (pend_valid),
    .pend_addr_o  (pend_addr)
  );

  // The tail of the frame may be shorter than a full burst.
  assign blen         = (32'(words_left_q) < BL_U) ? words_left_q : WCW'(BURST_LEN);
  assign data_ready   = (32'(fifo_level) >= 32'(blen));
  assign words_left_d = words_left_q - WCW'(1);

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q      <= S_IDLE;
      adr_q        <= '0;
      words_left_q <= '0;
      beat_cnt_q   <= '0;
      cyc_q        <= 1'b0;
      irq_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_ERROR: begin
          if (pend_valid) begin
            adr_q        <= pend_addr & 32'hFFFF_FFFC;
            words_left_q <= WCW'(FRAME_WORDS);
            err_q        <= 1'b0;
            state_q      <= S_WAIT_DATA;
          end
        end
        S_WAIT_DATA: begin
          if (data_ready) begin
            beat_cnt_q <= blen;
            cyc_q      <= 1'b1;
            state_q    <= S_BURST;
          end
        end
        S_BURST: begin
          // ERR has priority over a simultaneous ACK: nothing is popped.
          if (p_wb_ERR_I) begin
            cyc_q   <= 1'b0;
            err_q   <= 1'b1;
            irq_q   <= 1'b1;
            state_q <= S_ERROR;
          end else if (p_wb_ACK_I) begin
            adr_q        <= adr_q + 32'd4;
            words_left_q <= words_left_d;
            beat_cnt_q   <= beat_cnt_q - WCW'(1);
            if (beat_cnt_q == WCW'(1)) begin
              cyc_q <= 1'b0;
              if (words_left_d == '0) begin
                irq_q   <= 1'b1;
                state_q <= S_FRAME_DONE;
              end else begin
                state_q <= S_WAIT_DATA;
              end
            end
          end
        end
        S_FRAME_DONE: state_q <= S_IDLE;
        default:      state_q <= S_IDLE;
      endcase
    end
  end

  assign fifo_rd_en = (state_q == S_BURST) && p_wb_ACK_I && !p_wb_ERR_I;
  assign irq        = irq_q;
  assign err        = err_q;
  assign busy       = (state_q != S_IDLE);
  assign p_wb_CYC_O = cyc_q;
  assign p_wb_STB_O = cyc_q;
  assign p_wb_WE_O  = cyc_q;
  assign p_wb_SEL_O = WB_SEL_ALL;
  assign p_wb_ADR_O = adr_q;
  assign p_wb_DAT_O = fifo_data;

endmodule
